fetch: RTL and testbench

Instruction fetch stage: holds the architectural PC, issues word fetches to instruction memory over a valid/ready request/response handshake, and presents pc/next_pc/instruction/valid registers to decode. Redirects from execute (taken branch/jump) and writeback (trap/mret) replace the PC and squash any in-flight fetch. It sits between the instruction memory port and decode, and obeys the hazard unit's stall/invalidate.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_skid_buffer.sv | 50 +++++
 rtl/fetch.sv | 161 ++++++++++++++++
 tb/tb_fetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM state encoding,
// default reset vector, canonical NOP and PC increment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;
    localparam logic [31:0] INSTR_NOP            = 32'h0000_0013;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for a fetched instruction (pc + word) that arrived
// while the decode output register was blocked. Used only with FETCH_SKID_EN.
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_instr,
    input  logic        pop,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            pc_d    = push_pc;
            instr_d = push_instr;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, keeps one memory fetch outstanding and
// feeds decode through an output register. FETCH_SKID_EN adds a response skid slot.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        invalidate,
    input  logic        branch,
    input  logic [31:0] branch_address,
    input  logic        trap,
    input  logic [31:0] trap_address,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        mem_resp_ready,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_DROP = ST_DROP;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic [31:0] pc_out_q, pc_out_d, next_pc_out_q, next_pc_out_d, instr_q, instr_d;
    logic        valid_q, valid_d;

    logic        redirect, slot_free, req_fire, resp_fire, capture, flush;
    logic [31:0] target;

    assign redirect  = trap | branch;
    assign target    = trap ? trap_address : branch_address;
    assign slot_free = !stall || !valid_q;
    assign flush     = redirect || invalidate;

    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign resp_fire     = mem_resp_valid && mem_resp_ready;
    // A response only becomes an instruction when no redirect squashes it.
    assign capture       = (state_q == S_WAIT) && resp_fire && !redirect;

`ifdef FETCH_SKID_EN
    logic        buf_valid, buf_push, buf_pop;
    logic [31:0] buf_pc, buf_instr;

    assign buf_push = capture && !slot_free;
    assign buf_pop  = buf_valid && slot_free;
    assign mem_resp_ready = (state_q == S_DROP) || ((state_q == S_WAIT) && !buf_valid);

    fetch_skid_buffer u_skid (
        .clk       (clk),
        .rst       (reset),
        .flush     (flush),
        .push      (buf_push),
        .push_pc   (req_pc_q),
        .push_instr(mem_resp_data),
        .pop       (buf_pop),
        .valid     (buf_valid),
        .pc        (buf_pc),
        .instr     (buf_instr)
    );
`else
    assign mem_resp_ready = (state_q == S_DROP) || ((state_q == S_WAIT) && slot_free);
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
                // The request address may change freely until accepted.
                if (redirect) begin
                    pc_d = target;
                    if (req_fire) state_d = S_DROP;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = resp_fire ? S_REQ : S_DROP;
                end else if (resp_fire) begin
                    pc_d    = pc_plus4(req_pc_q);
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect) pc_d = target;
                if (resp_fire) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        valid_d       = valid_q;
        pc_out_d      = pc_out_q;
        next_pc_out_d = next_pc_out_q;
        instr_d       = instr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (slot_free) begin
`ifdef FETCH_SKID_EN
            if (buf_valid) begin
                valid_d       = 1'b1;
                pc_out_d      = buf_pc;
                next_pc_out_d = pc_plus4(buf_pc);
                instr_d       = buf_instr;
            end else
`endif
            if (capture) begin
                valid_d       = 1'b1;
                pc_out_d      = req_pc_q;
                next_pc_out_d = pc_plus4(req_pc_q);
                instr_d       = mem_resp_data;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_VECTOR;
            req_pc_q      <= '0;
            valid_q       <= 1'b0;
            pc_out_q      <= '0;
            next_pc_out_q <= '0;
            instr_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            valid_q       <= valid_d;
            pc_out_q      <= pc_out_d;
            next_pc_out_q <= next_pc_out_d;
            instr_q       <= instr_d;
        end
    end

    assign pc_out          = pc_out_q;
    assign next_pc_out     = next_pc_out_q;
    assign instruction_out = instr_q;
    assign valid_out       = valid_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: memory model + architectural PC-stream scoreboard, with
// directed scenarios followed by randomized stall/redirect/latency traffic.
module tb_fetch;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, invalidate, branch, trap;
    logic [31:0] branch_address, trap_address;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_req_addr, mem_resp_data;
    logic [31:0] pc_out, next_pc_out, instruction_out;
    logic        valid_out;

    always #5 clk = ~clk;

    fetch dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .invalidate     (invalidate),
        .branch         (branch),
        .branch_address (branch_address),
        .trap           (trap),
        .trap_address   (trap_address),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_ready (mem_resp_ready),
        .pc_out         (pc_out),
        .next_pc_out    (next_pc_out),
        .instruction_out(instruction_out),
        .valid_out      (valid_out)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] nxt_pc;
    int          vectors = 0, miscompares = 0, consumed = 0;
    int          req_acc = 0, resp_acc = 0;
    bit          pend = 1'b0;
    logic [31:0] paddr = '0;
    int          lat_cnt = 0;

    // Memory contents: any fixed word per address; RV maps to the NOP.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8000_0013;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(7))
            0:       return 32'hFFFF_FFFC;
            1:       return 32'hFFFF_FFF8;
            2:       return 32'h0000_0040;
            3:       return $urandom();
            default: return RV + {20'd0, 10'($urandom_range(1023)), 2'b00};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Expected decode stream: consecutive words from the latest redirect target.
    task automatic sb_top_up();
        while (exp_q.size() < 16) begin
            exp_q.push_back({nxt_pc, mem_word(nxt_pc)});
            nxt_pc = nxt_pc + 32'd4;
        end
    endtask

    task automatic sb_restart(input logic [31:0] t);
        exp_q.delete();
        nxt_pc = t;
        sb_top_up();
    endtask

    // One clock: drive at negedge, then at +3 advance memory and scoreboard
    // with what the upcoming rising edge will do. i: 0 none, 1 force, 2 random.
    task automatic step(input bit s, input int i, input bit b, input logic [31:0] bad,
                        input bit t, input logic [31:0] tad, input bit r,
                        input int rdy_pct, input int lat);
        @(negedge clk);
        reset          = r;
        stall          = s;
        branch         = b;
        branch_address = bad;
        trap           = t;
        trap_address   = tad;
        invalidate     = (i == 1) || (i == 2 && s && valid_out && !b && !t &&
                                      $urandom_range(3) == 0);
        mem_req_ready  = !r && (int'($urandom_range(99)) < rdy_pct);
        mem_resp_valid = !r && pend && lat_cnt == 0;
        mem_resp_data  = pend ? mem_word(paddr) : $urandom();
        #3;
        if (r) begin
            pend = 1'b0;
            sb_restart(RV);
        end else begin
            if (mem_resp_valid && mem_resp_ready) begin
                pend = 1'b0;
                resp_acc++;
            end
            if (mem_req_valid && mem_req_ready) begin
                chk("one_outstanding", {31'd0, pend}, 32'd0);
                pend    = 1'b1;
                paddr   = mem_req_addr;
                lat_cnt = (lat < 0) ? int'($urandom_range(3)) : lat;
                req_acc++;
            end else if (pend && lat_cnt > 0) begin
                lat_cnt--;
            end
            if (t)               sb_restart(tad);
            else if (b)         sb_restart(bad);
            else if (invalidate) void'(exp_q.pop_front());
            sb_top_up();
        end
    endtask

    // Monitor: decode consumes on valid_out && !stall; a stalled slot must hold.
    logic [31:0] h_pc, h_npc, h_ins;
    bit          hold_prev = 1'b0;

    always @(negedge clk) begin
        #2;
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_pc_out", pc_out, h_pc);
                chk("hold_next_pc_out", next_pc_out, h_npc);
                chk("hold_instruction_out", instruction_out, h_ins);
                chk("hold_valid_out", {31'd0, valid_out}, 32'd1);
            end
            if (valid_out && !stall) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_underflow: actual pc %h required none pending", pc_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pc_out", pc_out, mon_e.pc);
                    chk("instruction_out", instruction_out, mon_e.instr);
                    chk("next_pc_out", next_pc_out, mon_e.pc + 32'd4);
                    consumed++;
                end
            end
            hold_prev = valid_out && stall && !branch && !trap && !invalidate;
            h_pc  = pc_out;
            h_npc = next_pc_out;
            h_ins = instruction_out;
        end
    end

    logic [31:0] s_pc, s_ins;
    int          s_req, s_resp;

    initial begin
        reset = 1'b1; stall = 1'b0; invalidate = 1'b0; branch = 1'b0; trap = 1'b0;
        branch_address = '0; trap_address = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        sb_restart(RV);

        step(0, 0, 0, '0, 0, '0, 1, 0, 0);
        step(0, 0, 0, '0, 0, '0, 1, 0, 0);
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_next_pc_out", next_pc_out, 32'd0);
        chk("rst_instruction_out", instruction_out, 32'd0);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("rst_req_addr", mem_req_addr, RV);

        // Zero-wait memory: first word visible two cycles after the request.
        step(0, 0, 0, '0, 0, '0, 0, 100, 0);
        chk("t1_req_addr", mem_req_addr, RV);
        step(0, 0, 0, '0, 0, '0, 0, 100, 0);
        step(0, 0, 0, '0, 0, '0, 0, 100, 1);
        chk("t1_valid_out", {31'd0, valid_out}, 32'd1);
        chk("t1_pc_out", pc_out, RV);
        chk("t1_next_pc_out", next_pc_out, 32'h8000_0004);
        chk("t1_instruction_out", instruction_out, 32'h0000_0013);
        chk("t1_next_req_addr", mem_req_addr, 32'h8000_0004);

        // Branch while waiting; the late response must be dropped.
        step(0, 0, 1, 32'h8000_0100, 0, '0, 0, 100, 0);
        step(0, 0, 0, '0, 0, '0, 0, 100, 0);
        chk("t2_valid_squashed", {31'd0, valid_out}, 32'd0);
        chk("t2_drop_no_req", {31'd0, mem_req_valid}, 32'd0);

        // Trap beats a simultaneous branch.
        step(0, 0, 1, 32'h8000_0200, 1, 32'h0000_0040, 0, 0, 0);
        chk("t2_redirect_addr", mem_req_addr, 32'h8000_0100);
        step(0, 0, 0, '0, 0, '0, 0, 100, 0);
        chk("t3_trap_priority", mem_req_addr, 32'h0000_0040);
        step(0, 0, 0, '0, 0, '0, 0, 100, 0);

        // Five stalled cycles with a live instruction.
        step(1, 0, 0, '0, 0, '0, 0, 100, 0);
        chk("t4_valid_out", {31'd0, valid_out}, 32'd1);
        chk("t4_pc_out", pc_out, 32'h0000_0040);
        s_pc = pc_out; s_ins = instruction_out; s_req = req_acc; s_resp = resp_acc;
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, '0, 0, '0, 0, 100, 0);
            chk("t4_stall_pc_out", pc_out, s_pc);
            chk("t4_stall_instruction_out", instruction_out, s_ins);
            chk("t4_stall_valid_out", {31'd0, valid_out}, 32'd1);
`ifndef FETCH_SKID_EN
            chk("t4_resp_ready_low", {31'd0, mem_resp_ready}, 32'd0);
`endif
        end
`ifdef FETCH_SKID_EN
        chk("t4_stall_resp_taken", 32'(resp_acc - s_resp), 32'd1);
        chk("t4_stall_req_issued", 32'(req_acc - s_req), 32'd1);
        step(0, 0, 0, '0, 0, '0, 0, 100, 0);
`else
        chk("t4_stall_resp_taken", 32'(resp_acc - s_resp), 32'd0);
        chk("t4_stall_req_issued", 32'(req_acc - s_req), 32'd0);
        // Invalidate drops the held word; the PC stream carries on.
        step(1, 1, 0, '0, 0, '0, 0, 100, 0);
        step(0, 0, 0, '0, 0, '0, 0, 100, 0);
        chk("t5_valid_cleared", {31'd0, valid_out}, 32'd0);
        step(0, 0, 0, '0, 0, '0, 0, 100, 0);
        chk("t5_valid_out", {31'd0, valid_out}, 32'd1);
        chk("t5_pc_continues", pc_out, 32'h0000_0044);
`endif

        // Wrap-around at the top of the address space.
        for (int k = 0; k < 20; k++) begin
            if (mem_req_valid) break;
            step(0, 0, 0, '0, 0, '0, 0, 0, 0);
        end
        chk("t6_reach_req", {31'd0, mem_req_valid}, 32'd1);
        step(0, 0, 1, 32'hFFFF_FFFC, 0, '0, 0, 0, 0);
        step(0, 0, 0, '0, 0, '0, 0, 100, 0);
        chk("t6_req_addr", mem_req_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, '0, 0, '0, 0, 100, 0);
        step(0, 0, 0, '0, 0, '0, 0, 100, 0);
        chk("t6_valid_out", {31'd0, valid_out}, 32'd1);
        chk("t6_pc_out", pc_out, 32'hFFFF_FFFC);
        chk("t6_next_pc_wrap", next_pc_out, 32'h0000_0000);
        chk("t6_req_addr_wrap", mem_req_addr, 32'h0000_0000);

        // Random traffic with one mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            bit s, b, t, r;
            int sel;
            s   = ($urandom_range(99) < 30);
            sel = int'($urandom_range(99));
            b   = (sel < 4);
            t   = (sel >= 97);
            r   = (n == 1500 || n == 1501);
`ifdef FETCH_SKID_EN
            step(s, 0, b, pick_target(), t, pick_target(), r, 70, -1);
`else
            step(s, 2, b, pick_target(), t, pick_target(), r, 70, -1);
`endif
        end
        chk("progress_consumed", {31'd0, consumed >= 200}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
